// File: rtl/sysa_pkg.sv
// sysa_pkg: shared widths, width check and saturation helper for the systolic array
package sysa_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W = 16;
  typedef enum logic [1:0] {SAT_NONE, SAT_HI, SAT_LO} sat_e;
  function automatic logic acc_fits(input int data_w, input int weight_w, input int acc_w);
    return acc_w >= data_w + weight_w;
  endfunction
  // carry/msb are bits [ACC_W] and [ACC_W-1] of the sum extended to ACC_W+1 bits
  function automatic sat_e sat_check(input logic carry, input logic msb, input logic sgn, input logic sat);
    return !sat ? SAT_NONE : sgn ? (carry == msb ? SAT_NONE : carry ? SAT_LO : SAT_HI) : carry ? SAT_HI : SAT_NONE;
  endfunction
endpackage

// File: rtl/sysa_pe_wbuf.sv
// sysa_pe_wbuf: double-buffered weight (shadow chain + active copy) and swap pipelining
module sysa_pe_wbuf import sysa_pkg::*; #(
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WEIGHT_W-1:0] w_in,
  input  logic                w_load,
  input  logic                w_swap,
  output logic [WEIGHT_W-1:0] w_active,
  output logic [WEIGHT_W-1:0] w_out,
  output logic                w_swap_out
);
  logic [WEIGHT_W-1:0] shadow_q, active_q;
  logic swap_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      swap_q <= 1'b0;
    end else begin
      if (w_load) shadow_q <= w_in;
      if (w_swap) active_q <= shadow_q;
      swap_q <= w_swap;
    end
  assign w_active = active_q;
  assign w_out = shadow_q;
  assign w_swap_out = swap_q;
endmodule

// File: rtl/sysa_pe_mac.sv
// sysa_pe_mac: weight-stationary systolic PE, down = sat(left*w_active + up), 1-cycle latency
module sysa_pe_mac import sysa_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SIGNED = 0,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DATA_W-1:0]   left,
  input  logic                left_valid,
  input  logic [ACC_W-1:0]    up,
  input  logic [WEIGHT_W-1:0] w_in,
  input  logic                w_load,
  input  logic                w_swap,
  input  logic                clr_sat,
  output logic [DATA_W-1:0]   right,
  output logic                right_valid,
  output logic [ACC_W-1:0]    down,
  output logic                down_valid,
  output logic [WEIGHT_W-1:0] w_out,
  output logic                w_swap_out,
  output logic                sat_flag
);
  localparam int PW = DATA_W + WEIGHT_W;
  localparam logic SGN = SIGNED != 0;
  if (!acc_fits(DATA_W, WEIGHT_W, ACC_W)) begin : g_acc_w_check
    $error("sysa_pe_mac: ACC_W must be >= DATA_W+WEIGHT_W");
  end
  logic [WEIGHT_W-1:0] w_act;
  logic [PW-1:0] prod;
  logic [ACC_W:0] sum;
  sat_e sat_code;
  logic [ACC_W-1:0] res, hi, lo, down_q, down_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic valid_q, valid_d, sat_q, sat_d;
  sysa_pe_wbuf #(.WEIGHT_W(WEIGHT_W)) u_wbuf (
    .clk(clk), .rst_n(rst_n), .w_in(w_in), .w_load(w_load), .w_swap(w_swap),
    .w_active(w_act), .w_out(w_out), .w_swap_out(w_swap_out)
  );
  // operands are extended to PW bits so one unsigned multiply serves both signed modes
  always_comb begin
    prod = {{WEIGHT_W{SGN & left[DATA_W-1]}}, left} * {{DATA_W{SGN & w_act[WEIGHT_W-1]}}, w_act};
    sum = {{(ACC_W+1-PW){SGN & prod[PW-1]}}, prod} + {SGN & up[ACC_W-1], up};
    sat_code = sat_check(sum[ACC_W], sum[ACC_W-1], SGN, SATURATE != 0);
    hi = SGN ? {1'b0, {(ACC_W-1){1'b1}}} : '1;
    lo = SGN ? {1'b1, {(ACC_W-1){1'b0}}} : '0;
    res = sat_code == SAT_HI ? hi : sat_code == SAT_LO ? lo : sum[ACC_W-1:0];
    valid_d = en ? left_valid : valid_q;
    right_d = en && left_valid ? left : right_q;
    down_d = en && left_valid ? res : down_q;
    sat_d = en ? (sat_q && !clr_sat) || (left_valid && sat_code != SAT_NONE) : sat_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      right_q <= '0;
      down_q <= '0;
      valid_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      right_q <= right_d;
      down_q <= down_d;
      valid_q <= valid_d;
      sat_q <= sat_d;
    end
  assign right = right_q;
  assign down = down_q;
  assign right_valid = valid_q;
  assign down_valid = valid_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_sysa_pe_mac.sv
// tb_sysa_pe_mac: directed vector table plus randomized run against an arithmetic model,
// driving an unsigned and a signed PE with the same inputs
module tb_sysa_pe_mac;
  logic clk = 0, rst_n = 0, en = 0, left_valid = 0, w_load = 0, w_swap = 0, clr_sat = 0;
  logic [7:0] left = 0, w_in = 0;
  logic [15:0] up = 0;
  logic [7:0] right_u, right_s, wo_u, wo_s;
  logic [15:0] down_u, down_s;
  logic rv_u, rv_s, dv_u, dv_s, swo_u, swo_s, sat_u, sat_s;
  int checks = 0, failures = 0;
  int m_act, m_sh, m_swo, m_right, m_du, m_ds, m_v, m_su, m_ss;
  typedef struct {int en, lv, l, u, wi, wl, ws, clr, du, r, v, wo, swo, su, ds, ss;} vec_t;
  vec_t vt[29];

  always #5 clk = ~clk;

  sysa_pe_mac u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .left(left), .left_valid(left_valid), .up(up),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clr_sat(clr_sat),
    .right(right_u), .right_valid(rv_u), .down(down_u), .down_valid(dv_u),
    .w_out(wo_u), .w_swap_out(swo_u), .sat_flag(sat_u)
  );
  sysa_pe_mac #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .left(left), .left_valid(left_valid), .up(up),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clr_sat(clr_sat),
    .right(right_s), .right_valid(rv_s), .down(down_s), .down_valid(dv_s),
    .w_out(wo_s), .w_swap_out(swo_s), .sat_flag(sat_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sx(input int v, input int w);
    return v >= (1 << (w - 1)) ? v - (1 << w) : v;
  endfunction

  task automatic model_reset();
    {m_act, m_sh, m_swo, m_right, m_du, m_ds, m_v, m_su, m_ss} = '0;
  endtask

  task automatic model_step();
    int l, u, pu, ps;
    l = int'(left);
    u = int'(up);
    if (en) begin
      m_v = int'(left_valid);
      m_su = int'(m_su != 0 && !clr_sat);
      m_ss = int'(m_ss != 0 && !clr_sat);
      if (left_valid) begin
        m_right = l;
        pu = l * m_act + u;
        if (pu > 65535) begin pu = 65535; m_su = 1; end
        m_du = pu;
        ps = sx(l, 8) * sx(m_act, 8) + sx(u, 16);
        if (ps > 32767) begin ps = 32767; m_ss = 1; end
        if (ps < -32768) begin ps = -32768; m_ss = 1; end
        m_ds = ps & 'hFFFF;
      end
    end
    if (w_swap) m_act = m_sh;
    if (w_load) m_sh = int'(w_in);
    m_swo = int'(w_swap);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".right_u"}, right_u, m_right);
    check({tag, ".right_s"}, right_s, m_right);
    check({tag, ".rv_u"}, rv_u, m_v);
    check({tag, ".dv_u"}, dv_u, m_v);
    check({tag, ".rv_s"}, rv_s, m_v);
    check({tag, ".dv_s"}, dv_s, m_v);
    check({tag, ".down_u"}, down_u, m_du);
    check({tag, ".down_s"}, down_s, m_ds);
    check({tag, ".w_out"}, wo_u, m_sh);
    check({tag, ".w_out_s"}, wo_s, m_sh);
    check({tag, ".swo"}, swo_u, m_swo);
    check({tag, ".swo_s"}, swo_s, m_swo);
    check({tag, ".sat_u"}, sat_u, m_su);
    check({tag, ".sat_s"}, sat_s, m_ss);
  endtask

  task automatic zero_check(input string tag);
    check({tag, ".down_u"}, down_u, 0);
    check({tag, ".down_s"}, down_s, 0);
    check({tag, ".right"}, {right_u, right_s}, 0);
    check({tag, ".valids"}, {rv_u, dv_u, rv_s, dv_s}, 0);
    check({tag, ".w_out"}, {wo_u, wo_s}, 0);
    check({tag, ".swo"}, {swo_u, swo_s}, 0);
    check({tag, ".sat"}, {sat_u, sat_s}, 0);
  endtask

  initial begin
    //        en lv l     u       wi    wl ws clr du      r     v wo    swo su ds      ss
    vt[0]  = '{0, 0, 0,    0,      3,    1, 0, 0,  0,      0,    0, 3,    0, 0, 0,      0};
    vt[1]  = '{0, 0, 0,    0,      0,    0, 1, 0,  0,      0,    0, 3,    1, 0, 0,      0};
    vt[2]  = '{1, 1, 5,    10,     0,    0, 0, 0,  25,     5,    1, 3,    0, 0, 25,     0};
    vt[3]  = '{1, 0, 0,    0,      'hFF, 1, 0, 0,  25,     5,    0, 'hFF, 0, 0, 25,     0};
    vt[4]  = '{1, 0, 0,    0,      0,    0, 1, 0,  25,     5,    0, 'hFF, 1, 0, 25,     0};
    vt[5]  = '{1, 1, 'hFF, 'hFFFF, 0,    0, 0, 0,  'hFFFF, 'hFF, 1, 'hFF, 0, 1, 0,      0};
    vt[6]  = '{1, 0, 0,    0,      0,    0, 0, 1,  'hFFFF, 'hFF, 0, 'hFF, 0, 0, 0,      0};
    vt[7]  = '{1, 1, 2,    100,    0,    0, 0, 0,  'h262,  2,    1, 'hFF, 0, 0, 'h62,   0};
    vt[8]  = '{0, 1, 7,    'h1234, 0,    0, 0, 0,  'h262,  2,    1, 'hFF, 0, 0, 'h62,   0};
    vt[9]  = '{0, 0, 9,    'hFFFF, 0,    0, 0, 1,  'h262,  2,    1, 'hFF, 0, 0, 'h62,   0};
    vt[10] = '{0, 1, 11,   5,      0,    0, 0, 0,  'h262,  2,    1, 'hFF, 0, 0, 'h62,   0};
    vt[11] = '{1, 0, 0,    0,      0,    0, 0, 0,  'h262,  2,    0, 'hFF, 0, 0, 'h62,   0};
    vt[12] = '{0, 0, 0,    0,      9,    1, 0, 0,  'h262,  2,    0, 9,    0, 0, 'h62,   0};
    vt[13] = '{0, 0, 0,    0,      3,    1, 0, 0,  'h262,  2,    0, 3,    0, 0, 'h62,   0};
    vt[14] = '{0, 0, 0,    0,      0,    0, 1, 0,  'h262,  2,    0, 3,    1, 0, 'h62,   0};
    vt[15] = '{0, 0, 0,    0,      7,    1, 0, 0,  'h262,  2,    0, 7,    0, 0, 'h62,   0};
    vt[16] = '{1, 1, 2,    0,      0,    0, 1, 0,  6,      2,    1, 7,    1, 0, 6,      0};
    vt[17] = '{1, 1, 2,    0,      0,    0, 0, 0,  14,     2,    1, 7,    0, 0, 14,     0};
    vt[18] = '{1, 1, 1,    0,      4,    1, 1, 0,  7,      1,    1, 4,    1, 0, 7,      0};
    vt[19] = '{1, 1, 1,    0,      0,    0, 0, 0,  7,      1,    1, 4,    0, 0, 7,      0};
    vt[20] = '{0, 0, 0,    0,      3,    1, 0, 0,  7,      1,    1, 3,    0, 0, 7,      0};
    vt[21] = '{0, 0, 0,    0,      0,    0, 1, 0,  7,      1,    1, 3,    1, 0, 7,      0};
    vt[22] = '{1, 1, 'hFE, 'hFFFF, 0,    0, 0, 0,  'hFFFF, 'hFE, 1, 3,    0, 1, 'hFFF9, 0};
    vt[23] = '{1, 0, 0,    0,      'h7F, 1, 0, 0,  'hFFFF, 'hFE, 0, 'h7F, 0, 1, 'hFFF9, 0};
    vt[24] = '{0, 0, 0,    0,      0,    0, 1, 0,  'hFFFF, 'hFE, 0, 'h7F, 1, 1, 'hFFF9, 0};
    vt[25] = '{1, 1, 'h80, 'h8000, 0,    0, 0, 0,  'hBF80, 'h80, 1, 'h7F, 0, 1, 'h8000, 1};
    vt[26] = '{0, 0, 0,    0,      'h80, 1, 0, 0,  'hBF80, 'h80, 1, 'h80, 0, 1, 'h8000, 1};
    vt[27] = '{0, 0, 0,    0,      0,    0, 1, 0,  'hBF80, 'h80, 1, 'h80, 1, 1, 'h8000, 1};
    vt[28] = '{1, 1, 'h80, 'h7FFF, 0,    0, 0, 1,  'hBFFF, 'h80, 1, 'h80, 0, 0, 'h7FFF, 1};

    #12 zero_check("reset");
    #3 rst_n = 1;
    #1;
    for (int i = 0; i < 29; i++) begin
      en = 1'(vt[i].en); left_valid = 1'(vt[i].lv); left = 8'(vt[i].l); up = 16'(vt[i].u);
      w_in = 8'(vt[i].wi); w_load = 1'(vt[i].wl); w_swap = 1'(vt[i].ws); clr_sat = 1'(vt[i].clr);
      step();
      check($sformatf("v%0d.down_u", i), down_u, vt[i].du);
      check($sformatf("v%0d.right", i), right_u, vt[i].r);
      check($sformatf("v%0d.valid", i), {rv_u, dv_u, rv_s, dv_s}, {4{1'(vt[i].v)}});
      check($sformatf("v%0d.w_out", i), wo_u, vt[i].wo);
      check($sformatf("v%0d.swo", i), swo_u, vt[i].swo);
      check($sformatf("v%0d.sat_u", i), sat_u, vt[i].su);
      check($sformatf("v%0d.down_s", i), down_s, vt[i].ds);
      check($sformatf("v%0d.sat_s", i), sat_s, vt[i].ss);
    end

    // fresh start for the randomized run so the model begins from the reset state
    #3 rst_n = 0;
    #2 rst_n = 1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 3) != 0;
      left_valid = $urandom_range(0, 9) < 7;
      left = $urandom_range(0, 2) == 0 ? 8'(32'h7F80FF00 >> (8 * $urandom_range(0, 3))) : 8'($urandom);
      up = $urandom_range(0, 2) == 0 ? 16'(64'h7FFF8000FFFF0000 >> (16 * $urandom_range(0, 3))) : 16'($urandom);
      w_in = $urandom_range(0, 3) == 0 ? 8'(32'h7F80FF01 >> (8 * $urandom_range(0, 3))) : 8'($urandom);
      w_load = $urandom_range(0, 9) < 3;
      w_swap = $urandom_range(0, 9) < 2;
      clr_sat = $urandom_range(0, 9) == 0;
      step();
      cmp_model($sformatf("rnd%0d", i));
    end

    // asynchronous reset mid-cycle right after a valid compute
    en = 1; left_valid = 1; left = 3; up = 5; w_load = 0; w_swap = 0; clr_sat = 0;
    step();
    cmp_model("pre_areset");
    #3 rst_n = 0;
    #1 zero_check("areset");
    left = 4; up = 33;
    #2 rst_n = 1;
    model_reset();
    step();
    check("post_areset.down_u", down_u, 33);
    check("post_areset.down_s", down_s, 33);
    check("post_areset.right", right_u, 4);
    check("post_areset.valid", {rv_u, dv_u}, 2'b11);
    cmp_model("post_areset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
